// File: rtl/rename_ctrl_if.sv
// Rename-stage bus: decode group and flush in, RAT strobes and lookup results, one-entry holding register out to dispatch.
interface rename_ctrl_if;
  logic       flush;
  logic       in_valid;
  logic       in_ready;

  logic       in_inst1_valid;
  logic       in_inst1_rf_we;
  logic [5:0] in_inst1_src1;
  logic [5:0] in_inst1_src2;
  logic [5:0] in_inst1_dest;
  logic       in_inst2_valid;
  logic       in_inst2_rf_we;
  logic [5:0] in_inst2_src1;
  logic [5:0] in_inst2_src2;
  logic [5:0] in_inst2_dest;

  logic       free_list_empty;
  logic       rat_inst1_rf_we;
  logic       rat_inst2_rf_we;
  logic       src1_raw_hazard;
  logic       src2_raw_hazard;
  logic       dest_waw_hazard;
  logic       map_done;

  logic [5:0] rat_inst1_phy_src1;
  logic [5:0] rat_inst1_phy_src2;
  logic [5:0] rat_inst1_phy_dest;
  logic [5:0] rat_inst1_phy_old_dest;
  logic [5:0] rat_inst2_phy_src1;
  logic [5:0] rat_inst2_phy_src2;
  logic [5:0] rat_inst2_phy_dest;
  logic [5:0] rat_inst2_phy_old_dest;

  logic       out_valid;
  logic       out_ready;
  logic       out_inst1_valid;
  logic       out_inst2_valid;
  logic [5:0] out_inst1_phy_src1;
  logic [5:0] out_inst1_phy_src2;
  logic [5:0] out_inst1_phy_dest;
  logic [5:0] out_inst1_phy_old_dest;
  logic [5:0] out_inst2_phy_src1;
  logic [5:0] out_inst2_phy_src2;
  logic [5:0] out_inst2_phy_dest;
  logic [5:0] out_inst2_phy_old_dest;

  logic [31:0] perf_fl_stall_cnt;
  logic [31:0] perf_bp_stall_cnt;

  modport slave (
    input  flush, in_valid,
    input  in_inst1_valid, in_inst1_rf_we, in_inst1_src1, in_inst1_src2, in_inst1_dest,
    input  in_inst2_valid, in_inst2_rf_we, in_inst2_src1, in_inst2_src2, in_inst2_dest,
    input  free_list_empty,
    input  rat_inst1_phy_src1, rat_inst1_phy_src2, rat_inst1_phy_dest, rat_inst1_phy_old_dest,
    input  rat_inst2_phy_src1, rat_inst2_phy_src2, rat_inst2_phy_dest, rat_inst2_phy_old_dest,
    input  out_ready,
    output in_ready, rat_inst1_rf_we, rat_inst2_rf_we,
    output src1_raw_hazard, src2_raw_hazard, dest_waw_hazard, map_done,
    output out_valid, out_inst1_valid, out_inst2_valid,
    output out_inst1_phy_src1, out_inst1_phy_src2, out_inst1_phy_dest, out_inst1_phy_old_dest,
    output out_inst2_phy_src1, out_inst2_phy_src2, out_inst2_phy_dest, out_inst2_phy_old_dest,
    output perf_fl_stall_cnt, perf_bp_stall_cnt
  );

  modport master (
    output flush, in_valid,
    output in_inst1_valid, in_inst1_rf_we, in_inst1_src1, in_inst1_src2, in_inst1_dest,
    output in_inst2_valid, in_inst2_rf_we, in_inst2_src1, in_inst2_src2, in_inst2_dest,
    output free_list_empty,
    output rat_inst1_phy_src1, rat_inst1_phy_src2, rat_inst1_phy_dest, rat_inst1_phy_old_dest,
    output rat_inst2_phy_src1, rat_inst2_phy_src2, rat_inst2_phy_dest, rat_inst2_phy_old_dest,
    output out_ready,
    input  in_ready, rat_inst1_rf_we, rat_inst2_rf_we,
    input  src1_raw_hazard, src2_raw_hazard, dest_waw_hazard, map_done,
    input  out_valid, out_inst1_valid, out_inst2_valid,
    input  out_inst1_phy_src1, out_inst1_phy_src2, out_inst1_phy_dest, out_inst1_phy_old_dest,
    input  out_inst2_phy_src1, out_inst2_phy_src2, out_inst2_phy_dest, out_inst2_phy_old_dest,
    input  perf_fl_stall_cnt, perf_bp_stall_cnt
  );
endinterface

// File: rtl/rename_ctrl.sv
// Rename sequencer: combinational RAT strobes/hazards, result registered one cycle after map_done, stalls on empty free list or held group.
// Flush blocks renaming for RECOVER_CYCLES cycles; define RENAME_PERF_CNT_EN to build the stall counters.
module rename_ctrl #(
  parameter int unsigned RECOVER_CYCLES = 2
) (
  input  logic         clk,
  input  logic         reset,
  rename_ctrl_if.slave rif
);

  typedef enum logic {RUN = 1'b0, RECOVER = 1'b1} state_t;

  localparam logic [3:0] RECOVER_LOAD = 4'(RECOVER_CYCLES - 1);

  state_t          state;
  logic [3:0]      rcv_cnt;
  logic            we1;
  logic            we2;
  logic            can_advance;
  logic            map_go;
  logic            out_valid_q;
  logic            out_v1_q;
  logic            out_v2_q;
  logic [7:0][5:0] phy_d;
  logic [7:0][5:0] phy_q;
  logic            unused_inst1_srcs;

  assign we1 = rif.in_inst1_valid && rif.in_inst1_rf_we && (rif.in_inst1_dest != 6'd0);
  assign we2 = rif.in_inst2_valid && rif.in_inst2_rf_we && (rif.in_inst2_dest != 6'd0);

  assign rif.rat_inst1_rf_we = we1;
  assign rif.rat_inst2_rf_we = we2;
  assign rif.src1_raw_hazard = we1 && rif.in_inst2_valid && (rif.in_inst2_src1 == rif.in_inst1_dest);
  assign rif.src2_raw_hazard = we1 && rif.in_inst2_valid && (rif.in_inst2_src2 == rif.in_inst1_dest);
  assign rif.dest_waw_hazard = we1 && we2 && (rif.in_inst1_dest == rif.in_inst2_dest);

  // inst1 is the oldest slot, so its own sources can never depend on the group.
  assign unused_inst1_srcs = ^{rif.in_inst1_src1, rif.in_inst1_src2};

  assign can_advance = !out_valid_q || rif.out_ready;
  assign map_go      = !reset && !rif.flush && (state == RUN) && rif.in_valid &&
                       !rif.free_list_empty && can_advance;

  assign rif.map_done = map_go;
  assign rif.in_ready = map_go;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= RUN;
      rcv_cnt <= 4'd0;
    end else if (rif.flush) begin
      state   <= RECOVER;
      rcv_cnt <= RECOVER_LOAD;
    end else begin
      case (state)
        RUN:     state <= RUN;
        RECOVER: begin
          if (rcv_cnt == 4'd0) state <= RUN;
          else                 rcv_cnt <= rcv_cnt - 4'd1;
        end
        default: state <= RUN;
      endcase
    end
  end

  assign phy_d = {rif.rat_inst2_phy_old_dest, rif.rat_inst2_phy_dest,
                  rif.rat_inst2_phy_src2,     rif.rat_inst2_phy_src1,
                  rif.rat_inst1_phy_old_dest, rif.rat_inst1_phy_dest,
                  rif.rat_inst1_phy_src2,     rif.rat_inst1_phy_src1};

  // Data fields only move on map_done, which keeps them stable while dispatch stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_v1_q    <= 1'b0;
      out_v2_q    <= 1'b0;
      phy_q       <= '0;
    end else if (rif.flush) begin
      out_valid_q <= 1'b0;
    end else if (map_go) begin
      out_valid_q <= 1'b1;
      out_v1_q    <= rif.in_inst1_valid;
      out_v2_q    <= rif.in_inst2_valid;
      phy_q       <= phy_d;
    end else if (rif.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign rif.out_valid              = out_valid_q;
  assign rif.out_inst1_valid        = out_v1_q;
  assign rif.out_inst2_valid        = out_v2_q;
  assign rif.out_inst1_phy_src1     = phy_q[0];
  assign rif.out_inst1_phy_src2     = phy_q[1];
  assign rif.out_inst1_phy_dest     = phy_q[2];
  assign rif.out_inst1_phy_old_dest = phy_q[3];
  assign rif.out_inst2_phy_src1     = phy_q[4];
  assign rif.out_inst2_phy_src2     = phy_q[5];
  assign rif.out_inst2_phy_dest     = phy_q[6];
  assign rif.out_inst2_phy_old_dest = phy_q[7];

`ifdef RENAME_PERF_CNT_EN
  logic [31:0] fl_stall_cnt;
  logic [31:0] bp_stall_cnt;

  // Free-list stalls take precedence; a backpressure stall is only counted when registers were available.
  always_ff @(posedge clk) begin
    if (reset) begin
      fl_stall_cnt <= 32'd0;
      bp_stall_cnt <= 32'd0;
    end else if ((state == RUN) && rif.in_valid && !rif.flush) begin
      if (rif.free_list_empty)  fl_stall_cnt <= fl_stall_cnt + 32'd1;
      else if (!can_advance)    bp_stall_cnt <= bp_stall_cnt + 32'd1;
    end
  end

  assign rif.perf_fl_stall_cnt = fl_stall_cnt;
  assign rif.perf_bp_stall_cnt = bp_stall_cnt;
`else
  assign rif.perf_fl_stall_cnt = 32'd0;
  assign rif.perf_bp_stall_cnt = 32'd0;
`endif

endmodule

// File: doc/rename_ctrl.md
# rename_ctrl

Sequencing controller for the rename stage. Sits between decode and dispatch, and owns the two-wide register alias table and free list handshake. Each cycle it decides whether a decoded group may be renamed, and drives the allocation strobe and intra-group hazard flags into the RAT. It captures the RAT lookup results into a one-entry output register toward dispatch, and blocks renaming for a fixed recovery window after a pipeline flush.

## Interface
- RECOVER_CYCLES, 2: cycles rename stays blocked after a flush (legal range 1..15).
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- flush  in  1  pipeline flush (RAT restores committed state on the same edge)
- in_valid  in  1  decode presents a group
- in_ready  out  1  group consumed this cycle (equals map_done)
- in_inst{1,2}_valid  in  1  slot occupied
- in_inst{1,2}_rf_we  in  1  slot writes a GPR
- in_inst{1,2}_{src1,src2,dest}  in  6  architectural register addresses
- free_list_empty  in  1  RAT free list holds fewer than 2 entries
- rat_inst{1,2}_rf_we  out  1  gated allocation request to RAT
- src1_raw_hazard, src2_raw_hazard, dest_waw_hazard  out  1  intra-group hazard flags to RAT
- map_done  out  1  commit allocation in RAT this cycle
- rat_inst{1,2}_phy_{src1,src2,dest,old_dest}  in  6  RAT lookup results
- out_valid  out  1  renamed group held for dispatch
- out_ready  in  1  dispatch accepts the held group
- out_inst{1,2}_valid  out  1  registered slot valids
- out_inst{1,2}_phy_{src1,src2,dest,old_dest}  out  6  registered rename results
- perf_fl_stall_cnt, perf_bp_stall_cnt  out  32  stall cycle counters (see Configuration)

## Operation
- Gated write enable: rat_instN_rf_we = in_instN_valid && in_instN_rf_we && in_instN_dest != 0.
- src1_raw_hazard = rat_inst1_rf_we && in_inst2_valid && in_inst2_src1 == in_inst1_dest. src2_raw_hazard is defined the same way on src2.
- dest_waw_hazard = rat_inst1_rf_we && rat_inst2_rf_we && in_inst1_dest == in_inst2_dest.
- Hazard flags are purely combinational and are driven regardless of map_done.
- The FSM has two states, RUN and RECOVER, plus a 4-bit recovery counter.
  - Reset puts the FSM in RUN with counter 0.
  - flush in any state forces RECOVER and loads the counter with RECOVER_CYCLES-1.
  - In RECOVER, the counter decrements each cycle. The FSM moves to RUN on the cycle after the counter reaches 0.
- can_advance = !out_valid || out_ready.
- map_done = !reset && !flush && state==RUN && in_valid && !free_list_empty && can_advance.
- A group is all-or-nothing; slots are never split. When free_list_empty is set, the whole group stalls, even if it needs 0 or 1 registers.
- Output register:
  - When map_done is set, it loads the slot valids and all eight RAT phy values, and sets out_valid.
  - Otherwise, when out_ready is set, it clears out_valid.
  - flush clears out_valid. Data fields are don't-care while out_valid is 0.
- Simultaneous flush and map_done: flush wins. map_done is 0, so no allocation happens.

## Timing
- in_ready, map_done, rat_*_rf_we and the hazard flags are combinational from the current inputs and state. There is no registered delay into the RAT.
- The rename result is visible on out_* one cycle after map_done.
- With continuous out_ready and no stalls, throughput is one group per cycle.
- A flush at edge T blocks map_done for cycles T+1 through T+RECOVER_CYCLES. Rename resumes at T+RECOVER_CYCLES+1.
- A second flush during RECOVER reloads the counter, which extends the window.
- Reset values:
  - out_valid 0, out_inst*_valid 0, out phy fields 0.
  - FSM in RUN, perf counters 0.
  - map_done and in_ready are 0 while reset is asserted.
- Dispatch handshake: out_* must stay stable while out_valid && !out_ready.

## Configuration
- RENAME_PERF_CNT_EN defined:
  - perf_fl_stall_cnt increments on every cycle with state==RUN && in_valid && free_list_empty && !flush.
  - perf_bp_stall_cnt increments on every cycle with state==RUN && in_valid && !can_advance && !free_list_empty && !flush.
  - Both counters clear on reset and wrap modulo 2^32. Flush does not clear them.
- RENAME_PERF_CNT_EN undefined: both counter outputs are tied to 0 and no counter flops are instantiated. Ports remain present.

## Test plan
- Hazard group:
  - Stimulus: group inst1 dest=5 rf_we, inst2 src1=5 src2=5 dest=5 rf_we; free list available; out_ready=1.
  - Required: src1_raw_hazard=src2_raw_hazard=dest_waw_hazard=1 and map_done=1 that cycle; out_valid=1 next cycle.
- Zero destination:
  - Stimulus: inst1 dest=0 rf_we=1.
  - Required: rat_inst1_rf_we=0, no hazards flagged even if inst2 src1=0.
- Free list empty:
  - Stimulus: in_valid=1 with free_list_empty=1 for 3 cycles, then 0.
  - Required: map_done=0 for those 3 cycles and perf_fl_stall_cnt=3 with RENAME_PERF_CNT_EN (0 without); map_done=1 on the 4th cycle.
- Backpressure:
  - Stimulus: out_valid=1, out_ready=0, in_valid=1.
  - Required: map_done=0 and out_* held stable; out_ready=1 lets map_done=1 in the same cycle.
- Flush recovery:
  - Stimulus: flush at edge T with RECOVER_CYCLES=2, in_valid held high.
  - Required: out_valid=0 after T; map_done=0 at T+1 and T+2, 1 at T+3. A second flush at T+1 moves resume to T+4.
- Reset mid-stall:
  - Stimulus: assert reset while out_valid=1 in RECOVER.
  - Required: next cycle out_valid=0, state RUN, counters 0; map_done=1 on the first post-reset cycle with valid input.
